// File: rtl/mem_arb_pkg.sv
// Shared types for the multicycle MIPS memory arbiter.
//   arb_state_t : sequencer states
//   owner_t     : which requester holds (or last held) the memory port
//   CNT_W       : width of the read wait-state counter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_READ,
        ARB_WRITE,
        ARB_DONE
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_t;

    localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/mem_arbiter.sv
// Sequencer/arbiter for the single-port instruction/data memory.
// Grants the memory to the fetch path (IF) or the load/store path (LS), drives
// registered address/write data/strobe, counts RD_LAT read wait states and
// returns read data with a one-cycle acknowledge.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   if_req/if_addr             fetch read request (held until if_ack)
//   if_ack/if_rdata            fetch done pulse, fetched word (held)
//   ls_req/ls_we/ls_addr/ls_wdata  load/store request (held until ls_ack)
//   ls_ack/ls_rdata            load/store done pulse, loaded word (held)
//   mem_addr/mem_wdata/mem_wr  registered memory address, write data, strobe
//   mem_rdata                  memory read data
//   busy                       sequencer not idle
//   owner                      current/last grant (0 = IF, 1 = LS)
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_ack,
    output logic [DATA_W-1:0] ls_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              owner
);

    arb_state_t       state;
    owner_t           owner_q;
    owner_t           last_owner;
    logic [CNT_W-1:0] cnt;
    logic             grant_ls;

    // Round-robin: on a tie, hand the port to whoever was not granted last.
    always_comb begin
        grant_ls = 1'b0;
        if (if_req && ls_req) begin
            grant_ls = (last_owner == OWN_IF);
        end else begin
            grant_ls = ls_req;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ARB_IDLE;
            owner_q    <= OWN_IF;
            last_owner <= OWN_LS;
            cnt        <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wr     <= 1'b0;
            if_ack     <= 1'b0;
            ls_ack     <= 1'b0;
            if_rdata   <= '0;
            ls_rdata   <= '0;
        end else begin
            // Pulses default low; only the state transitions below raise them.
            if_ack <= 1'b0;
            ls_ack <= 1'b0;
            mem_wr <= 1'b0;
            unique case (state)
                ARB_IDLE: begin
                    if (if_req || ls_req) begin
                        owner_q    <= grant_ls ? OWN_LS : OWN_IF;
                        last_owner <= grant_ls ? OWN_LS : OWN_IF;
                        mem_addr   <= grant_ls ? ls_addr : if_addr;
                        if (grant_ls) begin
                            mem_wdata <= ls_wdata;
                        end
                        cnt <= CNT_W'(RD_LAT);
                        if (grant_ls && ls_we) begin
                            state  <= ARB_WRITE;
                            mem_wr <= 1'b1;
                        end else begin
                            state <= ARB_READ;
                        end
                    end
                end
                ARB_READ: begin
                    cnt <= cnt - 1'b1;
                    // Last wait cycle: mem_rdata is valid now, capture on entry to DONE.
                    if (cnt == CNT_W'(1)) begin
                        state <= ARB_DONE;
                        if (owner_q == OWN_LS) begin
                            ls_rdata <= mem_rdata;
                            ls_ack   <= 1'b1;
                        end else begin
                            if_rdata <= mem_rdata;
                            if_ack   <= 1'b1;
                        end
                    end
                end
                ARB_WRITE: begin
                    state <= ARB_DONE;
                    // Only LS can write, but follow the owner for symmetry.
                    if (owner_q == OWN_LS) begin
                        ls_ack <= 1'b1;
                    end else begin
                        if_ack <= 1'b1;
                    end
                end
                ARB_DONE: begin
                    state <= ARB_IDLE;
                end
                default: begin
                    state <= ARB_IDLE;
                end
            endcase
        end
    end

    assign busy  = (state != ARB_IDLE);
    assign owner = owner_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    typedef struct packed {
        logic        ls;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;

    // RD_LAT = 2 instance
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        ls_req = 1'b0;
    logic        ls_we = 1'b0;
    logic [31:0] ls_addr = '0;
    logic [31:0] ls_wdata = '0;
    logic        ls_ack;
    logic [31:0] ls_rdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_wr;
    logic [31:0] mem_rdata;
    logic        busy;
    logic        owner;

    // RD_LAT = 4 instance (fetch port only)
    logic        if_req4 = 1'b0;
    logic [31:0] if_addr4 = '0;
    logic        if_ack4;
    logic [31:0] if_rdata4;
    logic        ls_req4 = 1'b0;
    logic        ls_we4 = 1'b0;
    logic [31:0] ls_addr4 = '0;
    logic [31:0] ls_wdata4 = '0;
    logic        ls_ack4;
    logic [31:0] ls_rdata4;
    logic [31:0] mem_addr4;
    logic [31:0] mem_wdata4;
    logic        mem_wr4;
    logic [31:0] mem_rdata4;
    logic        busy4;
    logic        owner4;

    int   cyc = 0;
    int   checks = 0;
    int   passes = 0;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        if (a == 32'h4) return 32'h8C01_0008;
        return a ^ 32'h5A5A_0000 ^ {a[15:0], 16'h0};
    endfunction

    // Memory models: data valid RD_LAT cycles after the address is first presented.
    logic [31:0] a2_q;
    logic [31:0] a4_q [3];
    always @(posedge clk) begin
        a2_q    <= mem_addr;
        a4_q[0] <= mem_addr4;
        a4_q[1] <= a4_q[0];
        a4_q[2] <= a4_q[1];
    end
    assign mem_rdata  = mem_f(a2_q);
    assign mem_rdata4 = mem_f(a4_q[2]);

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(2)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_ack   (if_ack),
        .if_rdata (if_rdata),
        .ls_req   (ls_req),
        .ls_we    (ls_we),
        .ls_addr  (ls_addr),
        .ls_wdata (ls_wdata),
        .ls_ack   (ls_ack),
        .ls_rdata (ls_rdata),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_wr   (mem_wr),
        .mem_rdata(mem_rdata),
        .busy     (busy),
        .owner    (owner)
    );

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(4)) u_dut4 (
        .clk      (clk),
        .rst_n    (rst_n),
        .if_req   (if_req4),
        .if_addr  (if_addr4),
        .if_ack   (if_ack4),
        .if_rdata (if_rdata4),
        .ls_req   (ls_req4),
        .ls_we    (ls_we4),
        .ls_addr  (ls_addr4),
        .ls_wdata (ls_wdata4),
        .ls_ack   (ls_ack4),
        .ls_rdata (ls_rdata4),
        .mem_addr (mem_addr4),
        .mem_wdata(mem_wdata4),
        .mem_wr   (mem_wr4),
        .mem_rdata(mem_rdata4),
        .busy     (busy4),
        .owner    (owner4)
    );

    task automatic test_reset();
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passes++;
        checks++; if (owner !== 1'b0) $display("FAIL reset_owner: got %b want 0", owner); else passes++;
        checks++; if (mem_wr !== 1'b0) $display("FAIL reset_mem_wr: got %b want 0", mem_wr); else passes++;
        checks++; if ({if_ack, ls_ack} !== 2'b00) $display("FAIL reset_acks: got %b want 00", {if_ack, ls_ack}); else passes++;
        checks++; if (if_rdata !== 32'h0) $display("FAIL reset_if_rdata: got %h want 0", if_rdata); else passes++;
        checks++; if (ls_rdata !== 32'h0) $display("FAIL reset_ls_rdata: got %h want 0", ls_rdata); else passes++;
        checks++; if (mem_addr !== 32'h0) $display("FAIL reset_mem_addr: got %h want 0", mem_addr); else passes++;
        checks++; if (mem_wdata !== 32'h0) $display("FAIL reset_mem_wdata: got %h want 0", mem_wdata); else passes++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_if_read();
        exp_t e;
        int   t0;
        int   k;
        bit   seen = 1'b0;
        if_req = 1'b1; if_addr = 32'h4; t0 = cyc;
        e = '{ls: 1'b0, data: 32'h8C01_0008, cyc: 3}; sb.push_back(e);
        for (int n = 0; n < 8 && !seen; n++) begin
            @(negedge clk); k = cyc - t0;
            if (k == 1 || k == 2) begin
                checks++; if (mem_addr !== 32'h4) $display("FAIL if_read_addr c%0d: got %h want 4", k, mem_addr); else passes++;
            end
            checks++; if (ls_ack !== 1'b0) $display("FAIL if_read_no_ls_ack c%0d: got %b want 0", k, ls_ack); else passes++;
            if (if_ack === 1'b1) begin
                seen = 1'b1; e = sb.pop_front(); if_req = 1'b0;
                checks++; if (k !== e.cyc) $display("FAIL if_read_ack_cycle: got %0d want %0d", k, e.cyc); else passes++;
                checks++; if (if_rdata !== e.data) $display("FAIL if_read_data: got %h want %h", if_rdata, e.data); else passes++;
                checks++; if (owner !== 1'b0) $display("FAIL if_read_owner: got %b want 0", owner); else passes++;
            end
        end
        checks++; if (!seen) $display("FAIL if_read_timeout: got no ack want ack"); else passes++;
        if (!seen) sb.delete();
        @(negedge clk);
        checks++; if (busy !== 1'b0) $display("FAIL if_read_idle: got busy %b want 0", busy); else passes++;
    endtask

    task automatic test_store();
        exp_t e;
        int   t0;
        int   k;
        bit   seen = 1'b0;
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h40; ls_wdata = 32'hDEAD_BEEF; t0 = cyc;
        e = '{ls: 1'b1, data: 32'h0, cyc: 2}; sb.push_back(e);
        for (int n = 0; n < 8 && !seen; n++) begin
            @(negedge clk); k = cyc - t0;
            checks++; if (mem_wr !== (k == 1)) $display("FAIL store_mem_wr c%0d: got %b want %b", k, mem_wr, k == 1); else passes++;
            if (k == 1) begin
                checks++; if (mem_addr !== 32'h40) $display("FAIL store_addr: got %h want 40", mem_addr); else passes++;
                checks++; if (mem_wdata !== 32'hDEAD_BEEF) $display("FAIL store_wdata: got %h want deadbeef", mem_wdata); else passes++;
            end
            checks++; if (if_ack !== 1'b0) $display("FAIL store_no_if_ack c%0d: got %b want 0", k, if_ack); else passes++;
            if (ls_ack === 1'b1) begin
                seen = 1'b1; e = sb.pop_front(); ls_req = 1'b0; ls_we = 1'b0;
                checks++; if (k !== e.cyc) $display("FAIL store_ack_cycle: got %0d want %0d", k, e.cyc); else passes++;
                checks++; if (ls_rdata !== e.data) $display("FAIL store_ls_rdata: got %h want %h", ls_rdata, e.data); else passes++;
            end
        end
        checks++; if (!seen) $display("FAIL store_timeout: got no ack want ack"); else passes++;
        if (!seen) sb.delete();
        @(negedge clk);
        checks++; if (busy !== 1'b0) $display("FAIL store_idle: got busy %b want 0", busy); else passes++;
        checks++; if (mem_addr !== 32'h40) $display("FAIL store_addr_hold: got %h want 40", mem_addr); else passes++;
        checks++; if (mem_wr !== 1'b0) $display("FAIL store_wr_idle: got %b want 0", mem_wr); else passes++;
    endtask

    // Both held: IF wins first tie, LS wins the tie right after if_ack, then IF again.
    task automatic test_tie();
        exp_t e;
        int   t0;
        int   k;
        int   n_if = 0;
        logic got_ls;
        if_req = 1'b1; if_addr = 32'h100; ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h200; t0 = cyc;
        e = '{ls: 1'b0, data: mem_f(32'h100), cyc: 3};  sb.push_back(e);
        e = '{ls: 1'b1, data: mem_f(32'h200), cyc: 7};  sb.push_back(e);
        e = '{ls: 1'b0, data: mem_f(32'h100), cyc: 11}; sb.push_back(e);
        for (int n = 0; n < 20 && sb.size() != 0; n++) begin
            @(negedge clk); k = cyc - t0;
            if (k == 1) begin
                checks++; if (owner !== 1'b0) $display("FAIL tie_first_owner: got %b want 0", owner); else passes++;
            end
            if (k == 5) begin
                checks++; if (owner !== 1'b1) $display("FAIL tie_second_owner: got %b want 1", owner); else passes++;
            end
            checks++; if ((if_ack & ls_ack) !== 1'b0) $display("FAIL tie_double_ack c%0d: got 1 want 0", k); else passes++;
            if (if_ack === 1'b1 || ls_ack === 1'b1) begin
                got_ls = ls_ack; e = sb.pop_front();
                checks++; if (got_ls !== e.ls) $display("FAIL tie_order c%0d: got ls=%b want ls=%b", k, got_ls, e.ls); else passes++;
                checks++; if (k !== e.cyc) $display("FAIL tie_ack_cycle: got %0d want %0d", k, e.cyc); else passes++;
                checks++; if ((got_ls ? ls_rdata : if_rdata) !== e.data) $display("FAIL tie_data c%0d: got %h want %h", k, got_ls ? ls_rdata : if_rdata, e.data); else passes++;
                if (got_ls) ls_req = 1'b0;
                else begin n_if++; if (n_if == 2) if_req = 1'b0; end
            end
        end
        checks++; if (sb.size() != 0) $display("FAIL tie_timeout: got %0d pending want 0", sb.size()); else passes++;
        sb.delete(); if_req = 1'b0; ls_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_drop_req();
        exp_t e;
        int   t0;
        int   k;
        bit   seen = 1'b0;
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h300; t0 = cyc;
        e = '{ls: 1'b1, data: mem_f(32'h300), cyc: 3}; sb.push_back(e);
        for (int n = 0; n < 8 && !seen; n++) begin
            @(negedge clk); k = cyc - t0;
            if (k == 1) ls_req = 1'b0;
            checks++; if (if_ack !== 1'b0) $display("FAIL drop_no_if_ack c%0d: got %b want 0", k, if_ack); else passes++;
            if (ls_ack === 1'b1) begin
                seen = 1'b1; e = sb.pop_front();
                checks++; if (k !== e.cyc) $display("FAIL drop_ack_cycle: got %0d want %0d", k, e.cyc); else passes++;
                checks++; if (ls_rdata !== e.data) $display("FAIL drop_ls_rdata: got %h want %h", ls_rdata, e.data); else passes++;
                checks++; if (if_rdata !== mem_f(32'h100)) $display("FAIL drop_if_rdata_kept: got %h want %h", if_rdata, mem_f(32'h100)); else passes++;
            end
        end
        checks++; if (!seen) $display("FAIL drop_timeout: got no ack want ack"); else passes++;
        sb.delete();
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int   t0;
        int   k;
        bit   seen = 1'b0;
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h80; ls_wdata = 32'h1234_5678;
        @(negedge clk);
        checks++; if (mem_wr !== 1'b1) $display("FAIL rstmid_wr_before: got %b want 1", mem_wr); else passes++;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (mem_wr !== 1'b0) $display("FAIL rstmid_wr: got %b want 0", mem_wr); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL rstmid_busy: got %b want 0", busy); else passes++;
        checks++; if (ls_rdata !== 32'h0) $display("FAIL rstmid_ls_rdata: got %h want 0", ls_rdata); else passes++;
        ls_req = 1'b0; ls_we = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            checks++; if ({if_ack, ls_ack} !== 2'b00) $display("FAIL rstmid_no_ack: got %b want 00", {if_ack, ls_ack}); else passes++;
        end
        if_req = 1'b1; if_addr = 32'h4; ls_req = 1'b1; ls_addr = 32'h8; t0 = cyc;
        e = '{ls: 1'b0, data: 32'h8C01_0008, cyc: 3}; sb.push_back(e);
        for (int n = 0; n < 8 && !seen; n++) begin
            @(negedge clk); k = cyc - t0;
            if (k == 1) begin
                checks++; if (owner !== 1'b0) $display("FAIL rstmid_tie_owner: got %b want 0", owner); else passes++;
            end
            checks++; if (ls_ack !== 1'b0) $display("FAIL rstmid_tie_ls_ack c%0d: got %b want 0", k, ls_ack); else passes++;
            if (if_ack === 1'b1) begin
                seen = 1'b1; e = sb.pop_front(); if_req = 1'b0; ls_req = 1'b0;
                checks++; if (k !== e.cyc) $display("FAIL rstmid_tie_cycle: got %0d want %0d", k, e.cyc); else passes++;
                checks++; if (if_rdata !== e.data) $display("FAIL rstmid_tie_data: got %h want %h", if_rdata, e.data); else passes++;
            end
        end
        checks++; if (!seen) $display("FAIL rstmid_timeout: got no ack want ack"); else passes++;
        sb.delete();
        @(negedge clk);
        checks++; if (busy !== 1'b0) $display("FAIL rstmid_idle: got busy %b want 0", busy); else passes++;
    endtask

    task automatic test_lat4();
        exp_t e;
        int   t0;
        int   k;
        if_req4 = 1'b1; if_addr4 = 32'h44; t0 = cyc;
        e = '{ls: 1'b0, data: mem_f(32'h44), cyc: 5};  sb.push_back(e);
        e = '{ls: 1'b0, data: mem_f(32'h48), cyc: 11}; sb.push_back(e);
        for (int n = 0; n < 16 && sb.size() != 0; n++) begin
            @(negedge clk); k = cyc - t0;
            if (k == 6) begin
                checks++; if (busy4 !== 1'b0) $display("FAIL lat4_ack_cycle_req_ignored: got busy %b want 0", busy4); else passes++;
            end
            if (k == 7) begin
                checks++; if (busy4 !== 1'b1) $display("FAIL lat4_regrant: got busy %b want 1", busy4); else passes++;
                checks++; if (mem_addr4 !== 32'h48) $display("FAIL lat4_regrant_addr: got %h want 48", mem_addr4); else passes++;
            end
            checks++; if ({mem_wr4, ls_ack4} !== 2'b00) $display("FAIL lat4_no_ls: got %b want 00", {mem_wr4, ls_ack4}); else passes++;
            if (if_ack4 === 1'b1) begin
                e = sb.pop_front();
                checks++; if (k !== e.cyc) $display("FAIL lat4_ack_cycle: got %0d want %0d", k, e.cyc); else passes++;
                checks++; if (if_rdata4 !== e.data) $display("FAIL lat4_data: got %h want %h", if_rdata4, e.data); else passes++;
                if (sb.size() == 0) if_req4 = 1'b0;
                else if_addr4 = 32'h48;
            end
        end
        checks++; if (sb.size() != 0) $display("FAIL lat4_timeout: got %0d pending want 0", sb.size()); else passes++;
        sb.delete(); if_req4 = 1'b0;
        @(negedge clk);
        checks++; if ({owner4, ls_rdata4, mem_wdata4} !== 65'h0) $display("FAIL lat4_ls_side: got %h want 0", {owner4, ls_rdata4, mem_wdata4}); else passes++;
    endtask

    initial begin
        test_reset();
        test_if_read();
        test_store();
        test_tie();
        test_drop_req();
        test_reset_mid();
        test_lat4();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
